// File: rtl/enc_period_meas_pkg.sv
// Shared constants for the encoder period measurement block.
package enc_period_meas_pkg;

  localparam int PERIOD_W = 26;

  // Freeze value; identical to the velocity controller's freeze_perd.
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 26'h3FFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUB  = 2'd1,
    ST_GAP  = 2'd2
  } pub_state_t;

endpackage

// File: rtl/enc_period_meas_if.sv
// Encoder inputs and published {period, direction} results.
interface enc_period_meas_if;
  import enc_period_meas_pkg::*;

  logic                enable;
  logic                enc_a;
  logic                enc_b;
  logic [PERIOD_W-1:0] enc_period;
  logic                enc_dir;
  logic                enc_val_ready;
  logic                meas_overrun;

  // Side that drives the encoder inputs and consumes the results.
  modport master (
    output enable, enc_a, enc_b,
    input  enc_period, enc_dir, enc_val_ready, meas_overrun
  );

  // The measurement block itself.
  modport slave (
    input  enable, enc_a, enc_b,
    output enc_period, enc_dir, enc_val_ready, meas_overrun
  );

endinterface

// File: rtl/enc_sync2.sv
// Two-flop synchronizer with a delayed copy for level-change detection.
module enc_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic edge_det
);

  logic meta;
  logic prev;

  // Resynchronize the raw input and keep the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign edge_det = (sync != prev);

endmodule

// File: rtl/enc_period_meas.sv
// Encoder A-channel period and direction measurement with held-strobe publish.
//
// state   | meaning
// IDLE    | waiting for a new or pending sample to publish
// PUB     | enc_val_ready high, outputs frozen
// GAP     | enc_val_ready low, minimum spacing before the next publish
module enc_period_meas #(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [enc_period_meas_pkg::PERIOD_W-1:0] PERIOD_MAX =
    enc_period_meas_pkg::PERIOD_MAX,
  parameter int unsigned READY_LEN = 4,
  parameter int unsigned GAP_LEN   = 2
) (
  input logic               clk,
  input logic               reset,
  enc_period_meas_if.slave  bus
);
  import enc_period_meas_pkg::*;

  logic                a_sync, a_edge;
  logic                b_sync, b_edge;
  logic [7:0]          pre_cnt;
  logic                tick;
  logic [PERIOD_W-1:0] cnt, cnt_inc;
  logic                first_edge;
  logic                dir_prev;
  logic                edge_dir;
  logic                samp_vld;
  logic [PERIOD_W-1:0] samp_period;
  logic                samp_dir;
  logic                pend_vld;
  logic [PERIOD_W-1:0] pend_period;
  logic                pend_dir;
  pub_state_t          state;
  logic [7:0]          timer;

  enc_sync2 u_sync_a (.clk(clk), .reset(reset), .din(bus.enc_a), .sync(a_sync), .edge_det(a_edge));
  enc_sync2 u_sync_b (.clk(clk), .reset(reset), .din(bus.enc_b), .sync(b_sync), .edge_det(b_edge));

  assign tick     = (pre_cnt == 8'(CLK_DIV - 1));
  assign edge_dir = a_sync ^ b_sync;
  // The sample includes the tick of the edge cycle itself, so N cycles
  // between edges reads as N ticks.
  assign cnt_inc  = (tick && cnt != PERIOD_MAX) ? cnt + 1'b1 : cnt;

  // Form this cycle's sample: an edge measurement, or a one-shot stall report.
  always_comb begin
    samp_vld    = 1'b0;
    samp_period = PERIOD_MAX;
    samp_dir    = dir_prev;
    if (bus.enable && a_edge) begin
      samp_vld = 1'b1;
      samp_dir = edge_dir;
      if (!first_edge && edge_dir == dir_prev)
        samp_period = cnt_inc;
    end else if (bus.enable && cnt != PERIOD_MAX && cnt_inc == PERIOD_MAX) begin
      samp_vld = 1'b1;
    end
  end

  // Prescaler, saturating period counter and edge history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      first_edge <= 1'b1;
      dir_prev   <= 1'b0;
    end else if (!bus.enable) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      first_edge <= 1'b1;
    end else if (a_edge) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      first_edge <= 1'b0;
      dir_prev   <= edge_dir;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      cnt     <= cnt_inc;
    end
  end

  // Publish FSM with one-deep latest-wins pending buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_IDLE;
      timer             <= '0;
      bus.enc_period    <= PERIOD_MAX;
      bus.enc_dir       <= 1'b0;
      bus.enc_val_ready <= 1'b0;
      bus.meas_overrun  <= 1'b0;
      pend_vld          <= 1'b0;
      pend_period       <= PERIOD_MAX;
      pend_dir          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (samp_vld || (pend_vld && bus.enable)) begin
            bus.enc_period    <= samp_vld ? samp_period : pend_period;
            bus.enc_dir       <= samp_vld ? samp_dir : pend_dir;
            bus.enc_val_ready <= 1'b1;
            timer             <= 8'(READY_LEN - 1);
            state             <= ST_PUB;
            pend_vld          <= 1'b0;
            if (samp_vld && pend_vld)
              bus.meas_overrun <= 1'b1;
          end
        end
        ST_PUB: begin
          if (timer == 8'd0) begin
            bus.enc_val_ready <= 1'b0;
            timer             <= 8'(GAP_LEN - 1);
            state             <= ST_GAP;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ST_GAP: begin
          if (timer == 8'd0)
            state <= ST_IDLE;
          else
            timer <= timer - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase

      if (state != ST_IDLE && samp_vld) begin
        pend_vld    <= 1'b1;
        pend_period <= samp_period;
        pend_dir    <= samp_dir;
        if (pend_vld)
          bus.meas_overrun <= 1'b1;
      end

      if (!bus.enable) begin
        pend_vld         <= 1'b0;
        bus.meas_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/enc_period_meas.md
Name: enc_period_meas

Overview:
- Upstream stage of the velocity controller. Measures the period between successive encoder A-channel edges in prescaled sysclk ticks, and the direction at each edge.
- Publishes {period, direction} with a held ready strobe. This matches the controller's enc_fb / enc_dir_fb / enc_val_ready inputs, which rising-edge-detect ready through a 2-flop synchronizer.
- Reports the freeze value 26'h3FFFFFF when the period is invalid: stall, reversal, or no prior edge.

Parameters:
- CLK_DIV, 1, sysclk cycles per period-counter tick (1..255).
- PERIOD_MAX, 26'h3FFFFFF, saturation/freeze value reported for invalid or stalled periods.
- READY_LEN, 4, cycles enc_val_ready is held high per publish (>=3, so the consumer's 2-flop sync sees it).
- GAP_LEN, 2, minimum low cycles on enc_val_ready between publishes.

Ports:
- clk  in  1  system clock (~49.152 MHz).
- reset  in  1  synchronous reset, active-low.
- enable  in  1  measurement enable.
- enc_a  in  1  raw encoder channel A (asynchronous).
- enc_b  in  1  raw encoder channel B (asynchronous).
- enc_period  out  26  last published period in ticks, or PERIOD_MAX.
- enc_dir  out  1  direction at last published edge (1 = forward).
- enc_val_ready  out  1  publish strobe, high READY_LEN cycles.
- meas_overrun  out  1  sticky: a pending sample was overwritten before publish; cleared by reset or enable low.

Behaviour:
Reset (reset==0 at a clk edge):
- enc_period=PERIOD_MAX, enc_dir=0, enc_val_ready=0, meas_overrun=0.
- Counter=0, first_edge flag set, pending empty, state=IDLE.
- Synchronizer flops load 0.

Input path:
- enc_a and enc_b each pass through a 2-flop synchronizer, plus a prev register on A.
- A-edge = a_sync2 != a_prev; both A polarities count.
- Edge direction = a_sync2 XOR b_sync2, sampled in the same cycle.

Counter:
- Prescaler counts 0..CLK_DIV-1 and emits a tick on wrap.
- Period counter increments on tick and saturates at PERIOD_MAX (no wrap).
- On an A-edge, the counter clears to 0 in the same cycle; the pre-clear value is the sample.
- The prescaler also clears on an A-edge.

Sample value on an A-edge:
- first_edge set → PERIOD_MAX; first_edge is then cleared.
- Direction differs from the previous edge's direction → PERIOD_MAX (reversal).
- Otherwise → counter value (saturated).

Stall:
- When the counter first reaches PERIOD_MAX with no edge, generate one stall sample {PERIOD_MAX, last dir}.
- No further stall samples until an edge occurs.

Sample vs. stall in the same cycle: the edge sample wins.

Publish FSM (states IDLE, PUB, GAP):
- IDLE: a new sample or a pending sample is loaded into enc_period/enc_dir; enc_val_ready=1; → PUB.
- PUB: hold READY_LEN cycles, then enc_val_ready=0; → GAP.
- GAP: hold GAP_LEN cycles; → IDLE.
- Samples arriving in PUB/GAP go to a one-deep pending buffer, latest wins. Overwriting a full buffer sets meas_overrun.
- Output registers change only on the IDLE→PUB transition, so they are stable whenever ready is high.

Latency:
- enc_val_ready rises at the 3rd clk edge after the first edge that samples the new enc_a level (2 sync + 1 capture), when the FSM is in IDLE.
- enc_period and enc_dir update on that same edge.

Enable low:
- Counter, prescaler, pending and meas_overrun clear; first_edge sets.
- No new samples are generated; the FSM finishes the current PUB/GAP and returns to IDLE.
- Outputs hold their last values.
- On re-enable, the first edge publishes PERIOD_MAX.

Reset mid-PUB: enc_val_ready drops on the next edge; the pending sample is discarded.

Max publish rate: one per READY_LEN+GAP_LEN+1 cycles; faster edges are decimated (latest wins).

Decomposition:
- Shared constants package: PERIOD_MAX (26'h3FFFFFF, identical to the controller's freeze_perd), the 26-bit period width, and the FSM state encodings.
- Sub-module enc_sync2: 2-flop synchronizer with prev register and edge output, instantiated for A and B.

Test Plan:
- Reset and first edge: hold reset low 5 cycles, then check all outputs at reset values. With CLK_DIV=1, toggle A once with B=0 → enc_period=26'h3FFFFFF, enc_dir=1, ready high 4 cycles, rising 3 edges after A is sampled.
- Steady forward motion: A toggles every 100 clk, B held so XOR=1. The second and later publishes give enc_period=100 (edge-to-edge count) and enc_dir=1. Ready pattern is 4 high, ≥2 low.
- Reversal: after 3 forward edges, flip the B phase so direction = 0. The next publish is enc_period=PERIOD_MAX, enc_dir=0; the following one is the measured period with enc_dir=0.
- Stall with CLK_DIV=1 and a reduced PERIOD_MAX=1000 override: after one edge, no further edges. Exactly one publish {1000, last dir} occurs about 1000 cycles later, with no repeats.
- Burst and overrun: edges 2 cycles apart for 5 edges. Published values are the first sample and then the latest pending sample only; meas_overrun=1; enable low clears it.
- Enable drop mid-PUB: ready completes its 4 cycles and outputs hold. After re-enable the first edge publishes PERIOD_MAX.
